instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Fetch/decode/execute controller that drives the 16-bit GPR/SGPR datapath. Owns the program counter, fetches 32-bit instructions from a synchronous instruction memory, and presents each decoded instruction in the instruction register (IR). It hands the instruction to the datapath over a valid/ready handshake and detects halt, illegal opcodes and datapath stalls. It sits between the instruction memory and the register-file/ALU block and is the only writer of IR.

## Interface
- ADDR_W, 8, instruction memory address width; PC width
- TIMEOUT, 64, maximum cycles `exec_valid` may wait for `exec_ready` before error
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; starts execution at PC 0 from IDLE, HALT or ERROR
- imem_rd_en  out  1  instruction memory read strobe
- imem_addr  out  ADDR_W  read address (= PC)
- imem_rdata  in  32  read data, valid the cycle after `imem_rd_en`
- ir  out  32  current instruction; fields: oper[31:27], rdst[26:22], rsrc1[21:17], mode[16], rsrc2[15:11], imm[15:0]
- exec_valid  out  1  IR holds an instruction for the datapath
- exec_ready  in  1  datapath accepts; transfer when `exec_valid && exec_ready`
- busy  out  1  high in FETCH/DECODE/EXEC
- halted  out  1  high in HALT
- err_illegal  out  1  sticky, illegal opcode decoded
- err_timeout  out  1  sticky, handshake timeout
- instr_count  out  16  retired instructions since start, saturating

## Operation
- Legal opcodes: movsgpr 00000, mov 00001, add 00010, sub 00011, mul 00100, halt 11111. All others are illegal.
- States: IDLE, FETCH, DECODE, EXEC, HALT, ERROR.
- IDLE: outputs quiet. `start` → FETCH, pc=0, instr_count=0, error flags cleared.
- FETCH: `imem_rd_en`=1 and `imem_addr`=pc for exactly one cycle → DECODE.
- DECODE: `ir` ← `imem_rdata`; pc ← pc+1 (wraps modulo 2^ADDR_W). Next state decided on the captured opcode:
  - halt → HALT
  - illegal → ERROR with `err_illegal`=1
  - otherwise → EXEC
- EXEC: `exec_valid`=1, `ir` stable until handshake. On handshake: instr_count+1 (saturates at 0xFFFF) → FETCH.
- Watchdog: counts consecutive EXEC cycles with `exec_ready`=0. If it reaches TIMEOUT without a handshake → ERROR with `err_timeout`=1. The counter clears on entering EXEC. A multi-cycle mul in the datapath simply holds `exec_ready` low.
- HALT and ERROR: hold `ir`, pc and counters. `start` restarts exactly as from IDLE. Halt and illegal instructions are not counted.
- `start` while `busy`: ignored.
- Datapath semantics (GPR write, {SGPR,GPR} mul result) are not this block's concern. IR is passed unmodified.

## Timing
- Reset (`rst_n`=0 at clock edge):
  - state=IDLE, pc=0, `ir`=0
  - all outputs 0: `exec_valid`, `imem_rd_en`, `busy`, `halted`, error flags, `instr_count`
  - `imem_addr`=0
- Reset mid-operation abandons the instruction. `exec_valid` drops the next cycle with no handshake counted.
- Minimum 3 cycles per instruction (FETCH, DECODE, EXEC with `exec_ready`=1). Back-to-back throughput is 1 instruction per 3 cycles.
- First `imem_rd_en` occurs the cycle after `start` is sampled.
- `exec_valid` must not drop or `ir` change before the handshake, except on reset or timeout.
- Timeout: handshake at wait cycle TIMEOUT-1 is accepted. At TIMEOUT cycles with no handshake, ERROR is entered on the next edge.
- `start` and `rst_n`=0 in the same cycle: reset wins.

## Structure
- Shared package `proc_pkg`: opcode constants (existing five plus OP_HALT=11111), IR field bit positions, state enum `seq_state_t`.
- One sub-module: `exec_watchdog` (TIMEOUT-parameterised counter with clear/enable, `expired` output). Everything else in `instr_sequencer`.

## Test plan
- Program {mov r1,#5 (mode=1); add r2,r1,#3; halt} with `exec_ready` tied 1 → three `imem_rd_en` at addr 0,1,2; two handshakes 3 cycles apart; `halted`=1; `instr_count`=2.
- `exec_ready` held 0 for 4 cycles on a mul → `exec_valid` and `ir` stable throughout; handshake on cycle 5; `instr_count` increments once.
- Opcode 00101 at addr 0 → ERROR after DECODE; `err_illegal`=1; no `exec_valid`; `start` clears the flag and refetches addr 0.
- `exec_ready`=0 with TIMEOUT=64 → `err_timeout`=1 exactly 64 cycles after `exec_valid` rises. Repeat with ready at cycle 63 → no error.
- ADDR_W=2, four non-halt instructions → pc wraps, fifth fetch at addr 0.
- `rst_n`=0 during EXEC → next cycle IDLE, all outputs 0. `start` with `rst_n`=0 → stays IDLE.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer and its datapath neighbours:
// opcodes, IR field positions and the sequencer state type.
package proc_pkg;

  localparam logic [4:0] OP_MOVSGPR = 5'b00000;
  localparam logic [4:0] OP_MOV     = 5'b00001;
  localparam logic [4:0] OP_ADD     = 5'b00010;
  localparam logic [4:0] OP_SUB     = 5'b00011;
  localparam logic [4:0] OP_MUL     = 5'b00100;
  localparam logic [4:0] OP_HALT    = 5'b11111;

  localparam int OPER_MSB  = 31;
  localparam int OPER_LSB  = 27;
  localparam int RDST_MSB  = 26;
  localparam int RDST_LSB  = 22;
  localparam int RSRC1_MSB = 21;
  localparam int RSRC1_LSB = 17;
  localparam int MODE_BIT  = 16;
  localparam int RSRC2_MSB = 15;
  localparam int RSRC2_LSB = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT,
    ST_ERROR
  } seq_state_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    return (op == OP_MOVSGPR) || (op == OP_MOV) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_MUL) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/exec_watchdog.sv
// Counts consecutive stalled EXEC cycles; o_expired is combinational and fires in the
// stalled cycle that would be the TIMEOUT-th one, so the caller can leave on that edge.
module exec_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: 3 cycles minimum per instruction (FETCH, DECODE, EXEC).
// EXEC holds exec_valid and ir until exec_ready; a stall of TIMEOUT cycles aborts to ERROR.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic              busy,
  output logic              halted,
  output logic              err_illegal,
  output logic              err_timeout,
  output logic [15:0]       instr_count
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [15:0]       r_count;
  logic              r_err_ill;
  logic              r_err_to;

  logic       w_launch;
  logic       w_handshake;
  logic       w_expired;
  logic [4:0] w_rd_op;

  assign w_rd_op     = imem_rdata[OPER_MSB:OPER_LSB];
  assign w_launch    = start && ((r_state == ST_IDLE) || (r_state == ST_HALT) ||
                                 (r_state == ST_ERROR));
  assign w_handshake = exec_valid && exec_ready;

  exec_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (r_state != ST_EXEC),
    .i_en      ((r_state == ST_EXEC) && !exec_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    imem_rd_en = 1'b0;
    exec_valid = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        halted = (r_state == ST_HALT);
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_rd_en = 1'b1;
        busy       = 1'b1;
        w_next     = ST_DECODE;
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (w_rd_op == OP_HALT)        w_next = ST_HALT;
        else if (!is_legal_op(w_rd_op)) w_next = ST_ERROR;
        else                            w_next = ST_EXEC;
      end
      ST_EXEC: begin
        busy       = 1'b1;
        exec_valid = 1'b1;
        if (exec_ready)     w_next = ST_FETCH;
        else if (w_expired) w_next = ST_ERROR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // A restart and a decode can never coincide, so their updates of r_pc do not overlap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_count   <= '0;
      r_err_ill <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_pc      <= '0;
        r_count   <= '0;
        r_err_ill <= 1'b0;
        r_err_to  <= 1'b0;
      end
      if (r_state == ST_DECODE) begin
        r_ir <= imem_rdata;
        r_pc <= r_pc + ADDR_W'(1);
        if (!is_legal_op(w_rd_op)) r_err_ill <= 1'b1;
      end
      if (w_handshake && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
      if ((r_state == ST_EXEC) && w_expired) begin
        r_err_to <= 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign ir          = r_ir;
  assign err_illegal = r_err_ill;
  assign err_timeout = r_err_to;
  assign instr_count = r_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an instruction-level model predicts every output
// each cycle, and directed checks pin latencies, addresses and flags with literal values.
module tb_instr_sequencer;

  localparam int TO = 64;
  localparam logic [31:0] MOV_W  = {5'd1, 5'd1, 5'd0, 1'b1, 16'd5};
  localparam logic [31:0] ADD_W  = {5'd2, 5'd2, 5'd1, 1'b1, 16'd3};
  localparam logic [31:0] MUL_W  = {5'd4, 5'd3, 5'd1, 1'b0, 5'd2, 11'd0};
  localparam logic [31:0] HALT_W = 32'hF800_0000;
  localparam logic [31:0] ILL_W  = 32'h2800_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, exec_ready;
  logic        imem_rd_en, exec_valid, busy, halted, err_illegal, err_timeout;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata, ir;
  logic [15:0] instr_count;

  logic        start2, exec_ready2;
  logic        imem_rd_en2, exec_valid2, busy2, halted2, err_illegal2, err_timeout2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_rdata2, ir2;
  logic [15:0] instr_count2;

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [4];

  instr_sequencer #(.ADDR_W(8), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_rd_en(imem_rd_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ir(ir), .exec_valid(exec_valid),
    .exec_ready(exec_ready), .busy(busy), .halted(halted), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .instr_count(instr_count)
  );

  instr_sequencer #(.ADDR_W(2), .TIMEOUT(TO)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .imem_rd_en(imem_rd_en2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .ir(ir2), .exec_valid(exec_valid2),
    .exec_ready(exec_ready2), .busy(busy2), .halted(halted2), .err_illegal(err_illegal2),
    .err_timeout(err_timeout2), .instr_count(instr_count2)
  );

  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem1[imem_addr];
  always @(posedge clk) if (imem_rd_en2) imem_rdata2 <= mem2[imem_addr2];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // ---------------- event logs ----------------
  int fetch_q[$], fetch_cyc[$], hs_cyc[$], vrise_cyc[$], fetch2_q[$];
  int to_rise   = -1;
  int start_cyc = -1;
  logic prev_valid = 1'b0;
  logic prev_to    = 1'b0;

  initial forever begin
    @(negedge clk);
    if (imem_rd_en) begin
      fetch_q.push_back(int'(imem_addr));
      fetch_cyc.push_back(cyc);
    end
    if (exec_valid && exec_ready) hs_cyc.push_back(cyc);
    if (exec_valid && !prev_valid) vrise_cyc.push_back(cyc);
    if (err_timeout && !prev_to) to_rise = cyc;
    if (start && rst_n) start_cyc = cyc;
    if (imem_rd_en2) fetch2_q.push_back(int'(imem_addr2));
    prev_valid = exec_valid;
    prev_to    = err_timeout;
  end

  task automatic clear_logs();
    fetch_q.delete(); fetch_cyc.delete(); hs_cyc.delete(); vrise_cyc.delete();
    fetch2_q.delete();
    to_rise = -1;
  endtask

  // ---------------- instruction-level model ----------------
  bit          m_live = 1'b0;
  logic [7:0]  m_pc;
  logic [31:0] m_ir;
  logic [15:0] m_cnt;
  logic        m_halted, m_eill, m_eto;
  logic        e_rd_en, e_valid, e_busy;
  logic        s_start, s_rdy;

  task automatic tick(output bit rst_hit);
    @(posedge clk);
    s_start = start;
    s_rdy   = exec_ready;
    rst_hit = !rst_n;
    if (rst_hit) begin
      m_live = 1'b1; m_pc = '0; m_ir = '0; m_cnt = '0;
      m_halted = 1'b0; m_eill = 1'b0; m_eto = 1'b0;
    end
  endtask

  task automatic run_program();
    bit          r;
    logic [31:0] w;
    logic [4:0]  op;
    int          waits;
    m_pc = '0; m_cnt = '0; m_eill = 1'b0; m_eto = 1'b0; m_halted = 1'b0;
    forever begin
      e_rd_en = 1'b1; e_busy = 1'b1; e_valid = 1'b0;
      tick(r);
      if (r) return;
      e_rd_en = 1'b0;
      w = mem1[m_pc];
      tick(r);
      if (r) return;
      m_ir = w;
      m_pc = m_pc + 8'd1;
      op   = w[31:27];
      if (op == 5'b11111) begin m_halted = 1'b1; return; end
      if (op > 5'b00100)  begin m_eill = 1'b1; return; end
      waits   = 0;
      e_valid = 1'b1;
      forever begin
        tick(r);
        if (r) return;
        if (s_rdy) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          break;
        end
        waits++;
        if (waits == TO) begin m_eto = 1'b1; return; end
      end
    end
  endtask

  initial begin : model
    bit r;
    forever begin
      e_rd_en = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
      tick(r);
      if (!r && s_start) run_program();
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("m_rd_en",   imem_rd_en,  e_rd_en);
      chk("m_addr",    imem_addr,   m_pc);
      chk("m_ir",      ir,          m_ir);
      chk("m_valid",   exec_valid,  e_valid);
      chk("m_busy",    busy,        e_busy);
      chk("m_halted",  halted,      m_halted);
      chk("m_illegal", err_illegal, m_eill);
      chk("m_timeout", err_timeout, m_eto);
      chk("m_count",   instr_count, m_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk({name, "_quiet_in_time"}, busy, 1'b0);
    step();
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!exec_valid && n < budget);
    chk({name, "_valid_in_time"}, exec_valid, 1'b1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; exec_ready = 1'b1; exec_ready2 = 1'b1;
    for (int i = 0; i < 256; i++) mem1[i] = HALT_W;
    for (int i = 0; i < 4; i++)   mem2[i] = ADD_W;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", imem_rd_en, 1'b0);
    chk("rst_addr", imem_addr, 8'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_count", instr_count, 16'd0);
    chk("rst_flags", {exec_valid, halted, err_illegal, err_timeout}, 4'b0000);

    // program: mov, add, halt with ready tied high
    mem1[0] = MOV_W; mem1[1] = ADD_W; mem1[2] = HALT_W;
    step(); clear_logs();
    pulse_start();
    wait_quiet(60, "prog");
    chk("prog_nfetch", fetch_q.size(), 3);
    chk("prog_addr0", qget(fetch_q, 0), 0);
    chk("prog_addr1", qget(fetch_q, 1), 1);
    chk("prog_addr2", qget(fetch_q, 2), 2);
    chk("prog_first_fetch_lat", qget(fetch_cyc, 0) - start_cyc, 1);
    chk("prog_nhs", hs_cyc.size(), 2);
    chk("prog_hs_spacing", qget(hs_cyc, 1) - qget(hs_cyc, 0), 3);
    chk("prog_halted", halted, 1'b1);
    chk("prog_count", instr_count, 16'd2);
    chk("prog_ir", ir, HALT_W);

    // mul stalled 4 cycles, accepted on the 5th
    mem1[0] = MUL_W; mem1[1] = HALT_W;
    exec_ready = 1'b0; clear_logs();
    pulse_start();
    wait_valid(20, "mul");
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("mul_ir_stable", ir, MUL_W);
      chk("mul_valid_held", exec_valid, 1'b1);
    end
    step(); exec_ready = 1'b1;
    wait_quiet(30, "mul");
    chk("mul_nhs", hs_cyc.size(), 1);
    chk("mul_hs_wait", qget(hs_cyc, 0) - qget(vrise_cyc, 0), 4);
    chk("mul_count", instr_count, 16'd1);

    // illegal opcode, then restart clears the flag
    mem1[0] = ILL_W; clear_logs();
    pulse_start();
    wait_quiet(30, "ill");
    chk("ill_flag", err_illegal, 1'b1);
    chk("ill_no_valid", vrise_cyc.size(), 0);
    chk("ill_nfetch", fetch_q.size(), 1);
    chk("ill_ir", ir, ILL_W);
    mem1[0] = HALT_W; clear_logs();
    pulse_start();
    wait_quiet(30, "ill_restart");
    chk("ill_cleared", err_illegal, 1'b0);
    chk("ill_refetch0", qget(fetch_q, 0), 0);
    chk("ill_restart_halt", halted, 1'b1);

    // handshake timeout
    mem1[0] = ADD_W; mem1[1] = HALT_W;
    exec_ready = 1'b0; clear_logs();
    pulse_start();
    wait_quiet(120, "to");
    chk("to_flag", err_timeout, 1'b1);
    chk("to_latency", to_rise - qget(vrise_cyc, 0), 64);
    chk("to_no_hs", hs_cyc.size(), 0);
    chk("to_count", instr_count, 16'd0);

    // handshake on the last permitted wait cycle
    clear_logs();
    pulse_start();
    wait_valid(20, "to63");
    for (int i = 0; i < 62; i++) step();
    step(); exec_ready = 1'b1;
    wait_quiet(30, "to63");
    chk("to63_no_flag", err_timeout, 1'b0);
    chk("to63_hs_wait", qget(hs_cyc, 0) - qget(vrise_cyc, 0), 63);
    chk("to63_halted", halted, 1'b1);
    chk("to63_count", instr_count, 16'd1);

    // reset during EXEC, then start together with reset
    mem1[0] = ADD_W; exec_ready = 1'b0; clear_logs();
    pulse_start();
    wait_valid(20, "rst");
    step(); rst_n = 1'b0;
    step(); start = 1'b1;
    @(negedge clk);
    chk("rst_exec_valid", exec_valid, 1'b0);
    chk("rst_exec_busy", busy, 1'b0);
    chk("rst_exec_ir", ir, 32'd0);
    chk("rst_exec_count", instr_count, 16'd0);
    step(); rst_n = 1'b1; start = 1'b0; exec_ready = 1'b1;
    @(negedge clk);
    chk("rst_start_idle", busy, 1'b0);
    chk("rst_start_no_fetch", imem_rd_en, 1'b0);
    chk("rst_no_hs", hs_cyc.size(), 0);

    // narrow PC wraps after four instructions
    step(); clear_logs();
    start2 = 1'b1;
    step(); start2 = 1'b0;
    repeat (20) step();
    chk("wrap_nfetch_ge5", fetch2_q.size() >= 5, 1'b1);
    chk("wrap_a0", qget(fetch2_q, 0), 0);
    chk("wrap_a1", qget(fetch2_q, 1), 1);
    chk("wrap_a2", qget(fetch2_q, 2), 2);
    chk("wrap_a3", qget(fetch2_q, 3), 3);
    chk("wrap_a4", qget(fetch2_q, 4), 0);
    chk("wrap_no_err", {halted2, err_illegal2, err_timeout2}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: got still running, expected finished");
    $fatal(1);
  end

endmodule
